// File: rtl/rvfi_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between a fetch requester (I) and a
// load/store requester (D), with one access outstanding and a watchdog abort.
module rvfi_mem_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              i_valid,
    output logic              i_ready,
    input  logic [XLEN-1:0]   i_addr,
    output logic [XLEN-1:0]   i_rdata,
    output logic              i_err,

    input  logic              d_valid,
    output logic              d_ready,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [XLEN/8-1:0] d_wstrb,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_err,

    output logic              mem_valid,
    output logic              mem_instr,
    input  logic              mem_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int SW = XLEN / 8;
    localparam int AL = $clog2(SW);
    localparam logic [7:0] CNT_LAST = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t          state_q, state_d;
    logic            last_d_q, last_d_d;   // 1: D was granted last, so I wins a tie
    logic [7:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [SW-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic            mem_instr_q, mem_instr_d;

    logic            busy;
    logic            timeout_hit;
    logic            done;

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_instr_d = mem_instr_q;

        busy        = (state_q != IDLE);
        // A mem_ready in the final watchdog cycle wins over the abort
        timeout_hit = (TIMEOUT != 0) && busy && !mem_ready && (cnt_q == CNT_LAST);
        done        = busy && (mem_ready || timeout_hit);

        case (state_q)
            IDLE: begin
                if (i_valid && (!d_valid || last_d_q)) begin
                    state_d     = BUSY_I;
                    last_d_d    = 1'b0;
                    cnt_d       = 8'd0;
                    mem_addr_d  = {i_addr[XLEN-1:AL], {AL{1'b0}}};
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    mem_instr_d = 1'b1;
                end else if (d_valid) begin
                    state_d     = BUSY_D;
                    last_d_d    = 1'b1;
                    cnt_d       = 8'd0;
                    mem_addr_d  = {d_addr[XLEN-1:AL], {AL{1'b0}}};
                    mem_wdata_d = d_wdata;
                    mem_wstrb_d = d_wstrb;
                    mem_instr_d = 1'b0;
                end
            end
            default: begin
                if (done) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b1;
            cnt_q       <= 8'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            mem_instr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_instr_q <= mem_instr_d;
        end
    end

    assign mem_valid = busy;
    assign mem_instr = mem_instr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

    assign i_ready = (state_q == BUSY_I) && done;
    assign d_ready = (state_q == BUSY_D) && done;
    assign i_err   = (state_q == BUSY_I) && timeout_hit;
    assign d_err   = (state_q == BUSY_D) && timeout_hit;
    assign i_rdata = i_err ? '0 : mem_rdata;
    assign d_rdata = d_err ? '0 : mem_rdata;

endmodule

// File: tb/tb_rvfi_mem_arbiter.sv
// Randomized scoreboard bench for rvfi_mem_arbiter: stimulus predicts each completion,
// a monitor checks every ready pulse against the predicted transaction.
module tb_rvfi_mem_arbiter;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_valid, i_ready, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_valid, d_ready, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    rvfi_mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_err    (i_err),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wstrb  (d_wstrb),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .mem_valid(mem_valid),
        .mem_instr(mem_instr),
        .mem_ready(mem_ready),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          err;
        logic [31:0] rdata;
        int          cycles;
    } exp_t;

    typedef struct {
        int          lat;    // busy-cycle index in which mem_ready is raised
        logic [31:0] rdata;
    } resp_t;

    exp_t  exp_q[$];
    resp_t resp_q[$];

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;
    int busy_cnt  = 0;
    int txn_no    = 0;
    bit chk_idle  = 0;
    bit i_seen    = 0;
    bit d_seen    = 0;
    bit last_d    = 1;   // reference arbiter state: D granted last

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: what the requester must see for one granted access
    task automatic push_txn(input bit is_d, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input int lat, input logic [31:0] rdata);
        exp_t e;
        resp_t r;
        e.is_d   = is_d;
        e.addr   = addr & ~32'h3;
        e.wdata  = is_d ? wdata : 32'h0;
        e.wstrb  = is_d ? wstrb : 4'h0;
        e.err    = (lat >= TIMEOUT);
        e.rdata  = e.err ? 32'h0 : rdata;
        e.cycles = e.err ? TIMEOUT : lat + 1;
        exp_q.push_back(e);
        r.lat   = lat;
        r.rdata = rdata;
        resp_q.push_back(r);
    endtask

    // Issue requests (already placed on the address/data inputs) and wait for n completions.
    // lat < 0 picks a random latency per access.
    task automatic run(input bit wi, input bit wd, input int n, input bit drop_each,
                       input int lat, input logic [31:0] rdata);
        int start;
        int cyc;
        for (int j = 0; j < n; j++) begin
            bit is_d;
            int l;
            logic [31:0] rd;
            if (wi && wd) is_d = !last_d;
            else          is_d = wd;
            last_d = is_d;
            l  = (lat < 0) ? int'($urandom_range(0, 6)) : lat;
            rd = (lat < 0) ? $urandom : rdata;
            push_txn(is_d, is_d ? d_addr : i_addr, d_wdata, d_wstrb, l, rd);
        end
        i_seen  = 0;
        d_seen  = 0;
        i_valid = wi;
        d_valid = wd;
        start   = done_cnt;
        cyc     = 0;
        while ((done_cnt - start) < n && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (drop_each) begin
                if (i_seen) i_valid = 1'b0;
                if (d_seen) d_valid = 1'b0;
            end
            i_seen = 0;
            d_seen = 0;
        end
        i_valid = 1'b0;
        d_valid = 1'b0;
        if (cyc >= 200) begin
            checks++;
            failures++;
            $display("FAIL run_timeout completions=%0d required=%0d", done_cnt - start, n);
        end
    endtask

    // Memory responder: raises mem_ready in the scheduled busy cycle
    initial begin
        resp_t cur;
        int    k;
        bit    in_txn;
        cur.lat = 0;
        cur.rdata = 32'h0;
        k = 0;
        in_txn = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_valid) begin
                if (!in_txn) begin
                    in_txn = 1;
                    k = 0;
                    if (resp_q.size() > 0) cur = resp_q.pop_front();
                    else begin
                        cur.lat = 0;
                        cur.rdata = 32'h0;
                    end
                end
                mem_ready = (k == cur.lat);
                mem_rdata = cur.rdata;
                k++;
            end else begin
                in_txn = 0;
                mem_ready = 1'b0;
            end
        end
    end

    // Monitor: pops one prediction per ready pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                busy_cnt = 0;
                chk_idle = 0;
            end else begin
                if (mem_valid) busy_cnt++;
                if (i_ready || d_ready) begin
                    done_cnt++;
                    if (i_ready) i_seen = 1;
                    if (d_ready) d_seen = 1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_ready i_ready=%0b d_ready=%0b required=none",
                                 i_ready, d_ready);
                    end else begin
                        e = exp_q.pop_front();
                        txn_no++;
                        $display("txn %0d: %s addr=%h wstrb=%h err=%0b rdata=%h busy_cycles=%0d",
                                 txn_no, e.is_d ? "D" : "I", mem_addr, mem_wstrb,
                                 e.is_d ? d_err : i_err, e.is_d ? d_rdata : i_rdata, busy_cnt);
                        chk("grant_i_ready", i_ready, !e.is_d);
                        chk("grant_d_ready", d_ready, e.is_d);
                        chk("mem_instr", mem_instr, !e.is_d);
                        chk("mem_addr", mem_addr, e.addr);
                        chk("mem_wdata", mem_wdata, e.wdata);
                        chk("mem_wstrb", mem_wstrb, e.wstrb);
                        chk("err", {i_err, d_err}, e.is_d ? {1'b0, e.err} : {e.err, 1'b0});
                        chk("rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
                        chk("busy_cycles", busy_cnt, e.cycles);
                    end
                    busy_cnt = 0;
                    chk_idle = 1;
                end else if (chk_idle) begin
                    chk("idle_gap_mem_valid", mem_valid, 1'b0);
                    chk("idle_gap_err", {i_err, d_err}, 2'b00);
                    chk_idle = 0;
                end
            end
        end
    end

    initial begin
        resetn  = 1'b0;
        i_valid = 1'b0;
        d_valid = 1'b0;
        i_addr  = 32'h0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        d_wstrb = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_valid", mem_valid, 1'b0);
        chk("reset_mem_instr", mem_instr, 1'b0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_mem_wdata_wstrb", {mem_wdata, mem_wstrb}, 36'h0);
        chk("reset_ready", {i_ready, d_ready}, 2'b00);
        resetn = 1'b1;

        // Store with unaligned address, immediate memory response
        d_addr = 32'h1003; d_wdata = 32'hAABBCCDD; d_wstrb = 4'b0100;
        run(0, 1, 1, 1, 0, 32'h12345678);

        // Both held for three accesses: I, D, I
        i_addr = 32'h0000_0104; d_addr = 32'h0000_2008; d_wdata = 32'h1; d_wstrb = 4'hF;
        run(1, 1, 3, 0, 0, 32'h55AA55AA);

        // Fetch with three wait cycles
        i_addr = 32'h200;
        run(1, 0, 1, 1, 3, 32'h00000013);

        // Memory never answers: watchdog abort
        d_addr = 32'h3000; d_wstrb = 4'h0;
        run(0, 1, 1, 1, 255, 32'hDEADBEEF);

        // mem_ready in the last watchdog cycle is a normal completion
        d_addr = 32'h3004; d_wstrb = 4'h3; d_wdata = 32'hCAFE0000;
        run(0, 1, 1, 1, TIMEOUT - 1, 32'h0BADF00D);

        // Asynchronous reset in the middle of a D access
        d_addr = 32'h4000; d_wstrb = 4'hF; d_wdata = 32'h77;
        resp_q.push_back('{20, 32'h5});
        d_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("async_reset_mem_valid", mem_valid, 1'b0);
        chk("async_reset_mem_addr", mem_addr, 32'h0);
        chk("async_reset_mem_wdata_wstrb", {mem_wdata, mem_wstrb}, 36'h0);
        chk("async_reset_d_ready", d_ready, 1'b0);
        d_valid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        last_d = 1;
        i_addr = 32'h0000_0040; d_addr = 32'h0000_5001;
        run(1, 1, 2, 1, 1, 32'h9);

        // Random traffic
        for (int r = 0; r < 60; r++) begin
            int kind;
            kind    = $urandom_range(0, 3);
            i_addr  = $urandom;
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_wstrb = 4'($urandom_range(0, 15));
            case (kind)
                0:       run(1, 0, 1, 1, -1, 32'h0);
                1:       run(0, 1, 1, 1, -1, 32'h0);
                2:       run(1, 1, 2, 1, -1, 32'h0);
                default: run(1, 1, 3, 0, -1, 32'h0);
            endcase
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("responder_drained", resp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached checks=%0d", checks);
        $fatal(1, "simulation time limit");
    end

endmodule
